// File: rtl/est_deflate_update_pkg.sv
// Shared estimator definitions: FSM state encoding, fixed-point constants and
// the saturation helper reused by the deflation and normalisation stages.
package est_deflate_update_pkg;

    localparam int EST_DATA_WIDTH = 16;
    localparam int EST_FRAC_WIDTH = 12;
    localparam int EST_ONE        = 1 << EST_FRAC_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_SUB  = 2'd2,
        ST_DONE = 2'd3
    } est_state_t;

    // Clamp a wide signed value into the signed range of a dw-bit word.
    function automatic logic signed [63:0] sat_to_dw(input logic signed [63:0] x,
                                                     input int unsigned        dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/est_deflate_update_if.sv
// Start/done request and vector bus between the dot-product stage, the
// deflation update and the normalisation stage.
interface est_deflate_update_if #(
    parameter int DATA_WIDTH = 16,
    parameter int EXT_DIM    = 4
);
    logic                          start;
    logic [DATA_WIDTH-1:0]         dot_in;
    logic [DATA_WIDTH*EXT_DIM-1:0] vector_w;
    logic [DATA_WIDTH*EXT_DIM-1:0] vector_b;
    logic                          busy;
    logic                          done;
    logic [DATA_WIDTH*EXT_DIM-1:0] vector_out;
    logic                          sat_flag;

    modport master (
        output start, dot_in, vector_w, vector_b,
        input  busy, done, vector_out, sat_flag
    );

    modport slave (
        input  start, dot_in, vector_w, vector_b,
        output busy, done, vector_out, sat_flag
    );
endinterface

// File: rtl/est_deflate_update_fx_mul_shift.sv
// Registered signed fixed-point multiply; the full product is kept and the
// arithmetic right shift back to the shared format is applied on the output.
module fx_mul_shift #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic signed [DATA_WIDTH-1:0]   a,
    input  logic signed [DATA_WIDTH-1:0]   b,
    output logic signed [2*DATA_WIDTH-1:0] prod_shr
);
    logic signed [2*DATA_WIDTH-1:0] prod;

    always_ff @(posedge clk) begin
        if (rst)
            prod <= '0;
        else if (en)
            prod <= a * b;
    end

    // Floor toward -inf, no rounding.
    assign prod_shr = prod >>> FRAC_WIDTH;

endmodule

// File: rtl/est_deflate_update.sv
// Gram-Schmidt deflation step w' = w - d*b, one element per MULT/SUB pair,
// sharing a single registered multiplier across all elements.
module est_deflate_update
    import est_deflate_update_pkg::*;
#(
    parameter int DATA_WIDTH = EST_DATA_WIDTH,
    parameter int EXT_DIM    = 4,
    parameter int FRAC_WIDTH = EST_FRAC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    est_deflate_update_if.slave  bus
);
    localparam int VW    = DATA_WIDTH * EXT_DIM;
    localparam int IDX_W = (EXT_DIM > 1) ? $clog2(EXT_DIM) : 1;

    est_state_t state, state_nx;

    logic signed [DATA_WIDTH-1:0]   d_q;
    logic [VW-1:0]                  w_q;
    logic [VW-1:0]                  b_q;
    logic [VW-1:0]                  out_q;
    logic [IDX_W-1:0]               idx;
    logic                           sat_q;

    logic                           load;
    logic                           mul_en;
    logic                           write;
    logic                           last;
    logic                           busy;
    logic                           done;

    logic signed [DATA_WIDTH-1:0]   w_sel;
    logic signed [DATA_WIDTH-1:0]   b_sel;
    logic signed [DATA_WIDTH-1:0]   elem;
    logic signed [2*DATA_WIDTH-1:0] prod_shr;
    logic signed [63:0]             t_wide;
    logic signed [63:0]             t_sat;
    logic                           clip;

    assign last = (idx == IDX_W'(EXT_DIM - 1));

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (bus.start) state_nx = ST_MULT;
            ST_MULT: state_nx = ST_SUB;
            ST_SUB:  state_nx = last ? ST_DONE : ST_MULT;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        load   = (state == ST_IDLE) && bus.start;
        mul_en = (state == ST_MULT);
        write  = (state == ST_SUB);
        busy   = (state == ST_MULT) || (state == ST_SUB);
        done   = (state == ST_DONE);
    end

    always_comb begin
        w_sel = '0;
        b_sel = '0;
        for (int unsigned k = 0; k < EXT_DIM; k++) begin
            if (idx == IDX_W'(k)) begin
                w_sel = w_q[VW-1-k*DATA_WIDTH -: DATA_WIDTH];
                b_sel = b_q[VW-1-k*DATA_WIDTH -: DATA_WIDTH];
            end
        end
    end

    fx_mul_shift #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .en       (mul_en),
        .a        (d_q),
        .b        (b_sel),
        .prod_shr (prod_shr)
    );

    // Subtraction is done at 64 bits so even a full-scale shifted product
    // cannot wrap before the clamp; results in range match the narrow form.
    always_comb begin
        t_wide = 64'(w_sel) - 64'(prod_shr);
        t_sat  = sat_to_dw(t_wide, unsigned'(DATA_WIDTH));
        elem   = t_sat[DATA_WIDTH-1:0];
        clip   = (t_sat != t_wide);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q   <= '0;
            w_q   <= '0;
            b_q   <= '0;
            out_q <= '0;
            idx   <= '0;
            sat_q <= 1'b0;
        end else begin
            if (load) begin
                d_q   <= bus.dot_in;
                w_q   <= bus.vector_w;
                b_q   <= bus.vector_b;
                idx   <= '0;
                sat_q <= 1'b0;
            end
            if (write) begin
                for (int unsigned k = 0; k < EXT_DIM; k++) begin
                    if (idx == IDX_W'(k))
                        out_q[VW-1-k*DATA_WIDTH -: DATA_WIDTH] <= elem;
                end
                sat_q <= sat_q | clip;
                if (!last)
                    idx <= idx + IDX_W'(1);
            end
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.vector_out = out_q;
    assign bus.sat_flag   = sat_q;

endmodule
